// File: rtl/screen_fill_ctrl.sv
// -----------------------------------------------------------------------------
// screen_fill_ctrl
//
// Owns the single write port of the frame_buffer screen RAM and shares it
// between two requesters:
//   - Hack CPU screen writes, which always win and are never dropped;
//   - a built-in fill engine that sweeps every screen word with one pattern
//     (for example, clear-to-black).
//
// Every output is registered. A request sampled at edge N is visible on fb_*
// after edge N. CPU writes have priority over the fill engine. While a CPU
// write is in progress the fill engine stalls and holds its address counter,
// so a fill lasts exactly WORDS cycles plus one cycle per CPU write made
// during the fill.
//
// Parameters
//   ADDR_WIDTH      width of a screen word address
//   DATA_WIDTH      width of a screen word (16 pixels)
//   WORDS           number of words swept by a fill (last address is WORDS-1)
//   SYNC_TO_VBLANK  1: a fill waits for vblank before it starts; 0: a fill
//                   starts immediately
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   cpu_address   in   CPU screen word address
//   cpu_data      in   CPU write data
//   cpu_load      in   CPU write strobe, one word per cycle
//   fill_start    in   fill request (level, sampled in IDLE only)
//   fill_abort    in   cancels a pending or running fill
//   fill_pattern  in   fill word, latched when fill_start is accepted
//   vblank        in   high outside the visible VGA area
//   fb_address    out  frame_buffer write_address
//   fb_data       out  frame_buffer data_in
//   fb_load       out  frame_buffer load
//   fill_busy     out  high while a fill is pending or running
//   fill_done     out  one-cycle pulse together with the final fill write
// -----------------------------------------------------------------------------
module screen_fill_ctrl #(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 16,
    parameter int WORDS          = 8192,
    parameter int SYNC_TO_VBLANK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic                  cpu_load,
    input  logic                  fill_start,
    input  logic                  fill_abort,
    input  logic [DATA_WIDTH-1:0] fill_pattern,
    input  logic                  vblank,
    output logic [ADDR_WIDTH-1:0] fb_address,
    output logic [DATA_WIDTH-1:0] fb_data,
    output logic                  fb_load,
    output logic                  fill_busy,
    output logic                  fill_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        FILL    = 2'd2
    } state_t;

    // The counter carries one extra bit so a sweep of 2^ADDR_WIDTH words
    // never needs to represent a wrapped value.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(WORDS - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                state_reg;
    logic [ADDR_WIDTH:0]   fill_addr_reg;
    logic [DATA_WIDTH-1:0] pattern_reg;

    logic start_ok;
    logic start_now;
    logic fill_write;
    logic fill_last;

    // A request together with an abort is not a request.
    assign start_ok   = fill_start && !fill_abort;
    // Without vblank synchronisation the fill can always begin at once.
    assign start_now  = (SYNC_TO_VBLANK == 0) || vblank;
    // The fill engine only gets the port when the CPU does not want it, and
    // an abort suppresses the write that would otherwise go out this edge.
    assign fill_write = (state_reg == FILL) && !fill_abort && !cpu_load;
    assign fill_last  = (fill_addr_reg == LAST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            fill_addr_reg <= '0;
            pattern_reg   <= '0;
            fb_address    <= '0;
            fb_data       <= '0;
            fb_load       <= 1'b0;
            fill_busy     <= 1'b0;
            fill_done     <= 1'b0;
        end else begin
            fill_done <= 1'b0;

            // Write port arbitration: CPU first, then the sweep, else idle.
            // The address and data hold their values while the port is idle.
            if (cpu_load) begin
                fb_address <= cpu_address;
                fb_data    <= cpu_data;
                fb_load    <= 1'b1;
            end else if (fill_write) begin
                fb_address <= fill_addr_reg[ADDR_WIDTH-1:0];
                fb_data    <= pattern_reg;
                fb_load    <= 1'b1;
            end else begin
                fb_load    <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        pattern_reg   <= fill_pattern;
                        fill_addr_reg <= '0;
                        fill_busy     <= 1'b1;
                        state_reg     <= start_now ? FILL : WAIT_VB;
                    end
                end

                WAIT_VB: begin
                    if (fill_abort) begin
                        fill_addr_reg <= '0;
                        fill_busy     <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (vblank) begin
                        state_reg     <= FILL;
                    end
                end

                FILL: begin
                    if (fill_abort) begin
                        fill_addr_reg <= '0;
                        fill_busy     <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (!cpu_load) begin
                        // The counter only advances on edges where the sweep
                        // actually owned the port.
                        if (fill_last) begin
                            fill_addr_reg <= '0;
                            fill_busy     <= 1'b0;
                            fill_done     <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            fill_addr_reg <= fill_addr_reg + ADDR_ONE;
                        end
                    end
                end

                default: begin
                    fill_addr_reg <= '0;
                    fill_busy     <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_screen_fill_ctrl
//
// Randomised bench for screen_fill_ctrl. A behavioural model keeps a notion
// of "what the screen port should do at each edge": it schedules the expected
// frame_buffer write (stamped with its edge number) into a queue and keeps a
// picture of the RAM. A separate monitor compares the DUT port against the
// queue every cycle, along with fill_busy and fill_done.
// -----------------------------------------------------------------------------
module tb_screen_fill_ctrl;

    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int WORDS = 8192;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_FILL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [DW-1:0] cpu_data = '0;
    logic          cpu_load = 1'b0;
    logic          fill_start = 1'b0;
    logic          fill_abort = 1'b0;
    logic [DW-1:0] fill_pattern = '0;
    logic          vblank = 1'b0;
    logic [AW-1:0] fb_address;
    logic [DW-1:0] fb_data;
    logic          fb_load;
    logic          fill_busy;
    logic          fill_done;

    screen_fill_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .WORDS         (WORDS),
        .SYNC_TO_VBLANK(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_load    (cpu_load),
        .fill_start  (fill_start),
        .fill_abort  (fill_abort),
        .fill_pattern(fill_pattern),
        .vblank      (vblank),
        .fb_address  (fb_address),
        .fb_data     (fb_data),
        .fb_load     (fb_load),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] mdl_ram[WORDS];
    logic [DW-1:0] dut_ram[WORDS];

    int            cyc = 0;          // edges since reset release
    int            mode = M_IDLE;
    int            next_word = 0;    // next screen word the sweep will write
    logic [DW-1:0] mpat = '0;
    bit            exp_busy = 1'b0;
    bit            exp_done = 1'b0;
    int            cpu_in_fill = 0;

    task automatic model_write(input int addr, input logic [DW-1:0] data);
        wr_t w;
        w.cyc  = cyc;
        w.addr = AW'(addr);
        w.data = data;
        exp_q.push_back(w);
        mdl_ram[addr] = data;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0;
            mode = M_IDLE;
            next_word = 0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (cpu_load)
                model_write(int'(cpu_address), cpu_data);
            if (mode == M_IDLE) begin
                if (fill_start && !fill_abort) begin
                    mpat = fill_pattern;
                    next_word = 0;
                    exp_busy = 1'b1;
                    mode = vblank ? M_FILL : M_WAIT;
                end
            end else if (fill_abort) begin
                mode = M_IDLE;
                exp_busy = 1'b0;
            end else if (mode == M_WAIT) begin
                if (vblank) mode = M_FILL;
            end else begin
                if (cpu_load) begin
                    cpu_in_fill++;
                end else begin
                    model_write(next_word, mpat);
                    if (next_word == WORDS - 1) begin
                        exp_done = 1'b1;
                        exp_busy = 1'b0;
                        mode = M_IDLE;
                    end else begin
                        next_word++;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int done_pulses = 0;
    int busy_cycles = 0;

    always @(negedge clk) begin
        bit  want;
        wr_t e;
        if (!reset) begin
            want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("fb_load", 32'(fb_load), 32'(want));
            if (want) begin
                e = exp_q.pop_front();
                if (fb_load === 1'b1) begin
                    chk("fb_address", 32'(fb_address), 32'(e.addr));
                    chk("fb_data", 32'(fb_data), 32'(e.data));
                end
            end
            if (fb_load === 1'b1)
                dut_ram[fb_address] = fb_data;
            chk("fill_busy", 32'(fill_busy), 32'(exp_busy));
            chk("fill_done", 32'(fill_done), 32'(exp_done));
            if (fill_done === 1'b1) done_pulses++;
            if (fill_busy === 1'b1) busy_cycles++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic quiet_inputs();
        cpu_load   = 1'b0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
    endtask

    task automatic start_fill(input logic [DW-1:0] pat, input logic vb, input bit with_cpu);
        @(negedge clk);
        quiet_inputs();
        fill_start   = 1'b1;
        fill_pattern = pat;
        vblank       = vb;
        if (with_cpu) begin
            cpu_load    = 1'b1;
            cpu_address = AW'($urandom);
            cpu_data    = DW'($urandom);
        end
    endtask

    // Run until the model reports the fill finished. Optional CPU writes at
    // random intervals, an optional fill_start pulse at cycle pulse_at and an
    // optional fill_start raised for the completing edge.
    task automatic run_to_idle(input int cpu_writes, input int pulse_at,
                               input logic [DW-1:0] pulse_pat, input bit start_at_end);
        int n    = 0;
        int left = cpu_writes;
        int gap  = int'($urandom_range(5, 60));
        forever begin
            @(negedge clk);
            quiet_inputs();
            if (mode == M_IDLE) break;
            n++;
            if (n > 20000) begin
                chk("fill_timeout", 32'd1, 32'd0);
                break;
            end
            vblank = 1'($urandom_range(0, 1));
            if (left > 0) begin
                if (gap == 0) begin
                    cpu_load    = 1'b1;
                    cpu_address = AW'($urandom);
                    cpu_data    = DW'($urandom);
                    left--;
                    gap = int'($urandom_range(20, 100));
                end else begin
                    gap--;
                end
            end
            if (n == pulse_at) begin
                fill_start   = 1'b1;
                fill_pattern = pulse_pat;
            end
            if (start_at_end && mode == M_FILL && next_word == WORDS - 1 && !cpu_load) begin
                fill_start   = 1'b1;
                fill_pattern = pulse_pat;
            end
        end
    endtask

    task automatic settle();
        repeat (4) begin
            @(negedge clk);
            quiet_inputs();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0, b0, c0, mism, n;
        logic [DW-1:0] pat_a, pat_b;

        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_fb_load", 32'(fb_load), 32'd0);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_fb_address", 32'(fb_address), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        settle();

        // Immediate fill of zeros, no CPU traffic.
        d0 = done_pulses;
        start_fill(16'h0000, 1'b1, 1'b0);
        run_to_idle(0, 0, '0, 1'b0);
        settle();
        chk("clear_done_pulses", 32'(done_pulses - d0), 32'd1);
        chk("clear_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("fill 0000 complete, done pulses %0d", done_pulses - d0);

        // Fill of FFFF with 100 CPU writes; start coincides with a CPU write.
        d0 = done_pulses;
        b0 = busy_cycles;
        c0 = cpu_in_fill;
        start_fill(16'hFFFF, 1'b1, 1'b1);
        run_to_idle(100, 0, '0, 1'b0);
        settle();
        chk("cpu_done_pulses", 32'(done_pulses - d0), 32'd1);
        chk("cpu_duration", 32'(busy_cycles - b0), 32'(WORDS + cpu_in_fill - c0));
        mism = 0;
        for (int i = 0; i < WORDS; i++)
            if (dut_ram[i] !== mdl_ram[i]) mism++;
        chk("cpu_ram_image", 32'(mism), 32'd0);
        $display("fill FFFF with %0d cpu writes, %0d busy cycles", cpu_in_fill - c0, busy_cycles - b0);

        // vblank-synchronised start: nothing happens until vblank is seen.
        d0 = done_pulses;
        start_fill(16'hA5C3, 1'b0, 1'b0);
        n = int'($urandom_range(10, 40));
        repeat (n) begin
            @(negedge clk);
            quiet_inputs();
            vblank = 1'b0;
        end
        chk("wait_busy", 32'(fill_busy), 32'd1);
        @(negedge clk);
        quiet_inputs();
        vblank = 1'b1;
        run_to_idle(0, 0, '0, 1'b0);
        settle();
        chk("vb_done_pulses", 32'(done_pulses - d0), 32'd1);
        $display("vblank-gated fill after %0d wait cycles complete", n);

        // Abort at address 4000, then restart with a fresh pattern.
        d0 = done_pulses;
        pat_a = DW'($urandom);
        pat_b = ~pat_a;
        start_fill(pat_a, 1'b1, 1'b0);
        n = 0;
        forever begin
            @(negedge clk);
            quiet_inputs();
            n++;
            if (mode == M_FILL && next_word == 4000) begin
                fill_abort = 1'b1;
                break;
            end
            if (n > 20000) begin
                chk("abort_timeout", 32'd1, 32'd0);
                break;
            end
        end
        settle();
        repeat (20) @(negedge clk);
        chk("abort_busy", 32'(fill_busy), 32'd0);
        chk("abort_no_done", 32'(done_pulses - d0), 32'd0);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        start_fill(pat_b, 1'b1, 1'b0);
        run_to_idle(10, 0, '0, 1'b0);
        settle();
        chk("restart_done_pulses", 32'(done_pulses - d0), 32'd1);
        $display("abort at 4000 then restart with %h complete", pat_b);

        // Start pulsed mid-fill and again on the completing edge: both ignored.
        d0 = done_pulses;
        pat_a = DW'($urandom);
        start_fill(pat_a, 1'b1, 1'b0);
        run_to_idle(0, 10, ~pat_a, 1'b1);
        settle();
        chk("restart_ignored_done", 32'(done_pulses - d0), 32'd1);
        chk("restart_ignored_busy", 32'(fill_busy), 32'd0);
        mism = 0;
        for (int i = 0; i < WORDS; i++)
            if (dut_ram[i] !== pat_a) mism++;
        chk("restart_ignored_pattern", 32'(mism), 32'd0);
        $display("fill %h with ignored restarts complete", pat_a);

        // Reset in the middle of a running fill.
        d0 = done_pulses;
        start_fill(16'h1234, 1'b1, 1'b0);
        repeat (300) begin
            @(negedge clk);
            quiet_inputs();
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_fb_load", 32'(fb_load), 32'd0);
        chk("midrst_fill_busy", 32'(fill_busy), 32'd0);
        chk("midrst_fill_done", 32'(fill_done), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", 32'(done_pulses - d0), 32'd0);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("reset during fill handled");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        chk("global_timeout", 32'd1, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
